axi_pcie_v1_09_a_axi_enhanced_tx_pkt_fifo: RTL and testbench
============================================================

AXI_PCIE_V1_09_A_AXI_ENHANCED_TX_PKT_FIFO -- requirements
Module: axi_pcie_v1_09_a_axi_enhanced_tx_pkt_fifo

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32; data width, one of 32/64/128.
REQ-002 SHALL have parameter STRB_WIDTH, default C_DATA_WIDTH/8; strobe width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4; storage of 2^DEPTH_LOG2 beats.
REQ-004 SHALL have parameter TCQ, default 1; clock-to-Q delay.
REQ-005 SHALL have port com_iclk, input, 1 bit; the single clock.
REQ-006 SHALL have port com_sysrst, input, 1 bit; reset, synchronous and active-high.
REQ-007 SHALL have ports s_axis_tdata/tstrb/tlast/tuser[3:0]/tvalid as inputs and s_axis_tready as an output; these form the user-side slave stream.
REQ-008 SHALL have ports m_axis_tdata/tstrb/tlast/tuser[3:0]/tvalid as outputs and m_axis_tready as an input; these form the master stream that feeds one channel of the enhanced TX port mux.
REQ-009 SHALL have port trn_lnk_up, input, 1 bit; PCIe link up.
REQ-010 SHALL have port pkt_cnt, output, DEPTH_LOG2+1 bits; number of complete packets stored.
REQ-011 SHALL have port drop_pulse, output, 1 bit; one-cycle pulse when a packet is discarded.

Function
REQ-012 SHALL operate store-and-forward: m_axis_tvalid SHALL be high only when pkt_cnt>0.
REQ-013 SHALL track three pointers: wr_ptr, commit_ptr and rd_ptr, each DEPTH_LOG2+1 bits wide with a wrap bit; occupancy = wr_ptr - rd_ptr, computed modulo 2^(DEPTH_LOG2+1).
REQ-014 SHALL assign commit_ptr <= wr_ptr+1 and increment pkt_cnt on an accepted tlast beat; m_axis_tvalid SHALL then rise on the next cycle (1-cycle latency).
REQ-015 SHALL drive m_axis outputs from the storage array at rd_ptr; an output beat SHALL not change or withdraw while tvalid=1 and tready=0.
REQ-016 SHALL decrement pkt_cnt when an output tlast beat is accepted; a simultaneous commit and output tlast SHALL leave pkt_cnt unchanged.
REQ-017 SHALL implement the state machine ACCEPT, DROP and (with the macro) FLUSH; ACCEPT is the reset state.
REQ-018 In ACCEPT, SHALL set s_axis_tready = (occupancy < 2^DEPTH_LOG2) OR (cur_len == 2^DEPTH_LOG2), where cur_len counts the beats of the uncommitted packet.
REQ-019 Oversize: a valid beat with cur_len==2^DEPTH_LOG2 SHALL be discarded, wr_ptr SHALL rewind to commit_ptr, cur_len SHALL clear and drop_pulse SHALL be asserted; the next state SHALL be DROP if that beat is not tlast, else ACCEPT.
REQ-020 In DROP, SHALL hold s_axis_tready=1, discard all beats, and return to ACCEPT after the tlast beat.
REQ-021 A packet of exactly 2^DEPTH_LOG2 beats SHALL be accepted and forwarded intact.
REQ-022 SHALL set s_axis_tready=0 when the FIFO is full and cur_len < 2^DEPTH_LOG2; the FIFO SHALL resume accepting when the read side frees space.

Reset
REQ-023 On com_sysrst=1 at a clock edge, SHALL clear all pointers, cur_len and pkt_cnt, and set state=ACCEPT.
REQ-024 During and after reset, SHALL hold m_axis_tvalid=0, s_axis_tready=0 (while in reset) and drop_pulse=0; storage contents are don't-care.
REQ-025 Reset mid-packet on either side SHALL discard all stored and partial packets without emitting any beat.

Configuration
REQ-026 Macro AXI_PCIE_TX_PKT_FIFO_LNKDN_FLUSH_EN, when defined: trn_lnk_up=0 SHALL enter FLUSH, which resets the pointers and pkt_cnt, forces m_axis_tvalid=0, holds s_axis_tready=1 and discards input; FLUSH SHALL exit to ACCEPT on the first cycle with trn_lnk_up=1, entering DROP instead if an input packet is mid-flight.
REQ-027 When the macro is not defined, SHALL ignore trn_lnk_up and have no FLUSH state.

Verification
REQ-028 SHALL verify that a 3-beat packet (tlast on beat 3) with m_axis_tready=1 gives m_axis_tvalid rising 1 cycle after beat 3 is accepted, 3 beats out with identical data, and pkt_cnt going 0->1->0.
REQ-029 SHALL verify that a 16-beat packet (DEPTH_LOG2=4) is fully stored and forwarded with no drop_pulse.
REQ-030 SHALL verify that a 20-beat packet causes drop_pulse exactly once on beat 17, no output beats, beats 18-20 accepted, and a following 2-beat packet forwarded correctly.
REQ-031 SHALL verify that with two 8-beat packets stored and m_axis_tready=0, s_axis_tready=0 and pkt_cnt=2; releasing tready then yields 16 beats in order.
REQ-032 SHALL verify that an input tlast accepted in the same cycle as an output tlast leaves pkt_cnt=1 unchanged.
REQ-033 SHALL verify that with the macro defined, dropping trn_lnk_up with 1 packet stored gives pkt_cnt=0 and m_axis_tvalid=0 on the next cycle, and that no stale beats are emitted after the link returns.

Source files
------------

// File: rtl/axi_pcie_v1_09_a_axi_enhanced_tx_pkt_fifo.sv
// rtl/axi_pcie_v1_09_a_axi_enhanced_tx_pkt_fifo.sv - store-and-forward TX packet FIFO with oversize drop
// Optional link-down flush state: define AXI_PCIE_TX_PKT_FIFO_LNKDN_FLUSH_EN
module axi_pcie_v1_09_a_axi_enhanced_tx_pkt_fifo #(
    parameter int C_DATA_WIDTH = 32,
    parameter int STRB_WIDTH   = C_DATA_WIDTH / 8,
    parameter int DEPTH_LOG2   = 4,
    parameter int TCQ          = 1
) (
    input  logic                    com_iclk,
    input  logic                    com_sysrst,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [STRB_WIDTH-1:0]   s_axis_tstrb,
    input  logic                    s_axis_tlast,
    input  logic [3:0]              s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [STRB_WIDTH-1:0]   m_axis_tstrb,
    output logic                    m_axis_tlast,
    output logic [3:0]              m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic                    trn_lnk_up,
    output logic [DEPTH_LOG2:0]     pkt_cnt,
    output logic                    drop_pulse
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int EW    = C_DATA_WIDTH + STRB_WIDTH + 5;
    localparam logic [PW-1:0] FULL_LEN = PW'(DEPTH);
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam int unused_tcq = TCQ;

`ifdef AXI_PCIE_TX_PKT_FIFO_LNKDN_FLUSH_EN
    typedef enum logic [1:0] {ACCEPT, DROP, FLUSH} state_t;
    logic in_pkt;
`else
    typedef enum logic {ACCEPT, DROP} state_t;
    logic unused_lnk;
    assign unused_lnk = trn_lnk_up;
`endif

    state_t state, state_nxt;
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, cur_len, occupancy;
    logic          wr_en, commit, flush, m_fire, s_fire, out_last;

    assign occupancy = wr_ptr - rd_ptr;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata} = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign m_fire   = m_axis_tvalid & m_axis_tready;
    assign s_fire   = s_axis_tvalid & s_axis_tready;
    assign out_last = m_fire & m_axis_tlast;

    always_ff @(posedge com_iclk) begin
        if (com_sysrst) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        wr_en         = 1'b0;
        commit        = 1'b0;
        flush         = 1'b0;
        drop_pulse    = 1'b0;
        if (!com_sysrst) begin
            m_axis_tvalid = (pkt_cnt != '0);
            case (state)
                ACCEPT: begin
                    // A packet already at full depth keeps tready up so its overflow beat can be seen and dropped
                    s_axis_tready = (occupancy < FULL_LEN) || (cur_len == FULL_LEN);
                    if (s_axis_tvalid && s_axis_tready) begin
                        if (cur_len == FULL_LEN) begin
                            drop_pulse = 1'b1;
                            if (!s_axis_tlast) begin
                                state_nxt = DROP;
                            end
                        end else begin
                            wr_en  = 1'b1;
                            commit = s_axis_tlast;
                        end
                    end
                end
                DROP: begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_nxt = ACCEPT;
                    end
                end
`ifdef AXI_PCIE_TX_PKT_FIFO_LNKDN_FLUSH_EN
                FLUSH: begin
                    s_axis_tready = 1'b1;
                    m_axis_tvalid = 1'b0;
                    flush         = 1'b1;
                    if (trn_lnk_up) begin
                        state_nxt = (s_axis_tvalid ? !s_axis_tlast : in_pkt) ? DROP : ACCEPT;
                    end
                end
`endif
                default: state_nxt = ACCEPT;
            endcase
`ifdef AXI_PCIE_TX_PKT_FIFO_LNKDN_FLUSH_EN
            // Link loss overrides everything in the same cycle so no beat leaves or lands
            if (!trn_lnk_up) begin
                s_axis_tready = 1'b1;
                m_axis_tvalid = 1'b0;
                wr_en         = 1'b0;
                commit        = 1'b0;
                drop_pulse    = 1'b0;
                flush         = 1'b1;
                state_nxt     = FLUSH;
            end
`endif
        end
    end

    always_ff @(posedge com_iclk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tstrb, s_axis_tdata};
        end
    end

    always_ff @(posedge com_iclk) begin
        if (com_sysrst || flush) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            cur_len    <= '0;
            pkt_cnt    <= '0;
        end else begin
            if (drop_pulse) begin
                wr_ptr  <= commit_ptr;
                cur_len <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
                if (commit) begin
                    commit_ptr <= wr_ptr + ONE;
                    cur_len    <= '0;
                end else begin
                    cur_len <= cur_len + ONE;
                end
            end
            if (m_fire) begin
                rd_ptr <= rd_ptr + ONE;
            end
            pkt_cnt <= pkt_cnt + PW'(commit) - PW'(out_last);
        end
    end

`ifdef AXI_PCIE_TX_PKT_FIFO_LNKDN_FLUSH_EN
    always_ff @(posedge com_iclk) begin
        if (com_sysrst) begin
            in_pkt <= 1'b0;
        end else if (s_fire) begin
            in_pkt <= !s_axis_tlast;
        end
    end
`else
    logic unused_fire;
    assign unused_fire = s_fire;
`endif

endmodule

// File: tb/tb_axi_pcie_v1_09_a_axi_enhanced_tx_pkt_fifo.sv
// tb/tb_axi_pcie_v1_09_a_axi_enhanced_tx_pkt_fifo.sv - randomized self-checking bench for the TX packet FIFO
module tb_axi_pcie_v1_09_a_axi_enhanced_tx_pkt_fifo;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int DL = 4;
    localparam int BW = DW + SW + 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [SW-1:0] s_tstrb = '0;
    logic          s_tlast = 1'b0;
    logic [3:0]    s_tuser = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic          m_tlast;
    logic [3:0]    m_tuser;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          trn_lnk_up = 1'b1;
    logic [DL:0]   pkt_cnt;
    logic          drop_pulse;

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 1;
    int cyc = 0;
    int drop_cnt = 0;
    int drop_cyc = -1;
    int stall_viol = 0;
    int tvalid_viol = 0;
    bit abort = 0;
    bit holding = 0;
    logic [BW-1:0] held, mbeat;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] obs_q[$];

    axi_pcie_v1_09_a_axi_enhanced_tx_pkt_fifo #(
        .C_DATA_WIDTH(DW), .STRB_WIDTH(SW), .DEPTH_LOG2(DL), .TCQ(1)
    ) dut (
        .com_iclk(clk), .com_sysrst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .trn_lnk_up(trn_lnk_up), .pkt_cnt(pkt_cnt), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy_mode == 0) m_tready = 1'b0;
        else if (rdy_mode == 1) m_tready = 1'b1;
        else if (rdy_mode == 2) m_tready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: records handshaken beats, stall-stability and store-and-forward violations, drop pulses
    always @(negedge clk) begin
        #2;
        if (rst || !trn_lnk_up) begin
            holding = 0;
        end else begin
            mbeat = {m_tuser, m_tlast, m_tstrb, m_tdata};
            if (m_tvalid) begin
                if (holding && mbeat !== held) stall_viol++;
                if (pkt_cnt == 0) tvalid_viol++;
                if (m_tready) begin
                    obs_q.push_back(mbeat);
                    holding = 0;
                end else begin
                    holding = 1;
                    held = mbeat;
                end
            end else begin
                if (holding) stall_viol++;
                holding = 0;
            end
            if (drop_pulse) begin
                drop_cnt++;
                drop_cyc = cyc;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic drive_beat(input logic [BW-1:0] b, output int fire_cyc, output bit first_ready);
        int waited = 0;
        @(negedge clk);
        {s_tuser, s_tlast, s_tstrb, s_tdata} = b;
        s_tvalid = 1'b1;
        #1;
        while (!s_tready && waited < 3000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!s_tready) begin
            vectors++;
            miscompares++;
            $display("FAIL input_accept_timeout got tready=%0b want 1 after %0d cycles", s_tready, waited);
            abort = 1;
        end
        fire_cyc = cyc;
        first_ready = (waited == 0);
        @(posedge clk);
    endtask

    task automatic send_pkt(input int len, input bit keep, input int n_send);
        logic [BW-1:0] b;
        int fc;
        bit fr;
        bit last;
        for (int i = 0; i < n_send; i++) begin
            if (abort) break;
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                s_tvalid = 1'b0;
            end
            last = (i == len - 1);
            b = {4'($urandom), last, 4'($urandom), 32'($urandom)};
            if (keep) exp_q.push_back(b);
            drive_beat(b, fc, fr);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata = $urandom;
            #1;
            vectors++;
            if (s_tready !== 1'b0) begin miscompares++; $display("FAIL reset_s_tready got %0b want 0", s_tready); end
            vectors++;
            if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid got %0b want 0", m_tvalid); end
            vectors++;
            if (drop_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_drop_pulse got %0b want 0", drop_pulse); end
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({pkt_cnt, m_tvalid, s_tready} !== {5'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL post_reset got pkt_cnt=%0d m_tvalid=%0b s_tready=%0b want 0 0 1", pkt_cnt, m_tvalid, s_tready);
        end
    endtask

    task automatic test_basic();
        logic [BW-1:0] b;
        int fc;
        bit fr;
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                #1;
                vectors++;
                if ({pkt_cnt, m_tvalid} !== {5'd0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL basic_before_last got pkt_cnt=%0d m_tvalid=%0b want 0 0", pkt_cnt, m_tvalid);
                end
            end
            b = {4'($urandom), (i == 2), 4'($urandom), 32'($urandom)};
            exp_q.push_back(b);
            drive_beat(b, fc, fr);
        end
        #1;
        vectors++;
        if ({pkt_cnt, m_tvalid} !== {5'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL basic_after_last got pkt_cnt=%0d m_tvalid=%0b want 1 1", pkt_cnt, m_tvalid);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        wait_drain(3);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL basic_beat_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        vectors++;
        if ({pkt_cnt, m_tvalid} !== {5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_drained got pkt_cnt=%0d m_tvalid=%0b want 0 0", pkt_cnt, m_tvalid);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_full_packet();
        rdy_mode = 2;
        drop_cnt = 0;
        send_pkt(16, 1, 16);
        wait_drain(16);
        vectors++;
        if (obs_q.size() != 16) begin miscompares++; $display("FAIL full16_count got %0d want 16", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL full16_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        vectors++;
        if (drop_cnt != 0) begin miscompares++; $display("FAIL full16_drops got %0d want 0", drop_cnt); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_oversize();
        int fcs[20];
        bit frs[20];
        logic [BW-1:0] b;
        rdy_mode = 1;
        drop_cnt = 0;
        drop_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            b = {4'($urandom), (i == 19), 4'($urandom), 32'($urandom)};
            drive_beat(b, fcs[i], frs[i]);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (drop_cnt != 1) begin miscompares++; $display("FAIL oversize_drop_count got %0d want 1", drop_cnt); end
        vectors++;
        if (drop_cyc != fcs[16]) begin miscompares++; $display("FAIL oversize_drop_cycle got %0d want %0d", drop_cyc, fcs[16]); end
        for (int i = 17; i < 20; i++) begin
            vectors++;
            if (frs[i] !== 1'b1) begin miscompares++; $display("FAIL oversize_beat%0d_ready got %0b want 1", i + 1, frs[i]); end
        end
        vectors++;
        if (obs_q.size() != 0 || pkt_cnt != 0) begin
            miscompares++;
            $display("FAIL oversize_no_output got beats=%0d pkt_cnt=%0d want 0 0", obs_q.size(), pkt_cnt);
        end
        obs_q.delete();
        send_pkt(2, 1, 2);
        wait_drain(2);
        vectors++;
        if (obs_q.size() != 2) begin miscompares++; $display("FAIL oversize_next_count got %0d want 2", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL oversize_next_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        rdy_mode = 0;
        send_pkt(8, 1, 8);
        send_pkt(8, 1, 8);
        @(negedge clk);
        #1;
        vectors++;
        if ({s_tready, pkt_cnt, m_tvalid} !== {1'b0, 5'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL full_stall got tready=%0b pkt_cnt=%0d m_tvalid=%0b want 0 2 1", s_tready, pkt_cnt, m_tvalid);
        end
        rdy_mode = 1;
        wait_drain(16);
        vectors++;
        if (obs_q.size() != 16) begin miscompares++; $display("FAIL full_release_count got %0d want 16", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL full_release_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        vectors++;
        if (s_tready !== 1'b1) begin miscompares++; $display("FAIL full_resume got tready=%0b want 1", s_tready); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        logic [BW-1:0] b;
        int fc;
        bit fr;
        rdy_mode = 3;
        m_tready = 1'b0;
        send_pkt(1, 1, 1);
        b = {4'($urandom), 1'b0, 4'($urandom), 32'($urandom)};
        exp_q.push_back(b);
        drive_beat(b, fc, fr);
        @(negedge clk);
        b = {4'($urandom), 1'b1, 4'($urandom), 32'($urandom)};
        exp_q.push_back(b);
        {s_tuser, s_tlast, s_tstrb, s_tdata} = b;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        #1;
        vectors++;
        if ({pkt_cnt, m_tvalid, m_tlast, s_tready} !== {5'd1, 1'b1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL simul_setup got pkt_cnt=%0d mv=%0b ml=%0b sr=%0b want 1 1 1 1", pkt_cnt, m_tvalid, m_tlast, s_tready);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #1;
        vectors++;
        if (pkt_cnt !== 5'd1) begin miscompares++; $display("FAIL simul_pkt_cnt got %0d want 1", pkt_cnt); end
        rdy_mode = 1;
        wait_drain(3);
        vectors++;
        if (obs_q.size() != 3) begin miscompares++; $display("FAIL simul_count got %0d want 3", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL simul_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int len;
        int n_over = 0;
        rdy_mode = 2;
        drop_cnt = 0;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 20);
            if (len > 16) n_over++;
            send_pkt(len, len <= 16, len);
        end
        wait_drain(exp_q.size());
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL random_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        vectors++;
        if (drop_cnt != n_over) begin miscompares++; $display("FAIL random_drops got %0d want %0d", drop_cnt, n_over); end
        vectors++;
        if (stall_viol != 0) begin miscompares++; $display("FAIL stall_stability got %0d violations want 0", stall_viol); end
        vectors++;
        if (tvalid_viol != 0) begin miscompares++; $display("FAIL store_forward got %0d violations want 0", tvalid_viol); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        rdy_mode = 0;
        send_pkt(4, 0, 4);
        send_pkt(6, 0, 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({s_tready, m_tvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_outputs got tready=%0b m_tvalid=%0b want 0 0", s_tready, m_tvalid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rdy_mode = 1;
        repeat (30) @(negedge clk);
        vectors++;
        if (obs_q.size() != 0 || pkt_cnt != 0) begin
            miscompares++;
            $display("FAIL midreset_discard got beats=%0d pkt_cnt=%0d want 0 0", obs_q.size(), pkt_cnt);
        end
        obs_q.delete();
        send_pkt(3, 1, 3);
        wait_drain(3);
        vectors++;
        if (obs_q.size() != 3) begin miscompares++; $display("FAIL midreset_next_count got %0d want 3", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL midreset_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

`ifdef AXI_PCIE_TX_PKT_FIFO_LNKDN_FLUSH_EN
    task automatic test_lnk_flush();
        rdy_mode = 0;
        send_pkt(3, 0, 3);
        #1;
        vectors++;
        if (pkt_cnt !== 5'd1) begin miscompares++; $display("FAIL flush_setup got pkt_cnt=%0d want 1", pkt_cnt); end
        @(negedge clk);
        trn_lnk_up = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({pkt_cnt, m_tvalid} !== {5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL flush_clear got pkt_cnt=%0d m_tvalid=%0b want 0 0", pkt_cnt, m_tvalid);
        end
        repeat (3) @(negedge clk);
        trn_lnk_up = 1'b1;
        rdy_mode = 1;
        repeat (20) @(negedge clk);
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL flush_stale got %0d beats want 0", obs_q.size()); end
        obs_q.delete();
        send_pkt(2, 1, 2);
        wait_drain(2);
        vectors++;
        if (obs_q.size() != 2) begin miscompares++; $display("FAIL flush_next_count got %0d want 2", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL flush_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full_packet();
        test_oversize();
        test_backpressure();
        test_simultaneous();
        test_random();
        test_mid_reset();
`ifdef AXI_PCIE_TX_PKT_FIFO_LNKDN_FLUSH_EN
        test_lnk_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
